// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder slice (two half adders plus an OR)
// and a registered carry. The operands are consumed LSB first, one bit per
// clock, under a start/busy/done handshake.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    // Count value on the edge that processes the last bit (WIDTH-1)
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] part;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s1;
    logic             c1;
    logic             s_bit;
    logic             c2;
    logic             c_next;
    logic [WIDTH:0]   part_ext;
    logic [WIDTH-1:0] part_next;

    // Full-adder slice operating on the current LSBs and the stored carry
    half_adder ha_ab (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .s (s1),
        .c (c1)
    );

    half_adder ha_c (
        .a (s1),
        .b (carry),
        .s (s_bit),
        .c (c2)
    );

    assign c_next = c1 | c2;

    // The new sum bit enters at the MSB. Shifting through a one-bit-wider
    // vector keeps the expression legal at WIDTH=1.
    assign part_ext  = {s_bit, part};
    assign part_next = part_ext[WIDTH:1];

    // Handshake FSM together with the operand, carry, partial-sum and counter datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            part  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        part  <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    part  <= part_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= part_next;
                        cout  <= c_next;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial, multi-cycle unsigned adder. Adds two WIDTH-bit operands one bit per clock, LSB first, with a full-adder slice built from two half_adder instances plus an OR, and a registered carry. It sits directly upstream of result consumers in the lab datapath. It trades latency for area compared with a ripple adder. A start/busy/done handshake controls each operation.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  synchronous reset, active-low.
start  input  1  request to begin an addition; accepted only when busy=0.
a  input  WIDTH  operand A; sampled only on the accept edge.
b  input  WIDTH  operand B; sampled only on the accept edge.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse; sum and cout are valid from this cycle on.
sum  output  WIDTH  registered result, (a+b) mod 2^WIDTH.
cout  output  1  registered carry-out of the addition.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: rst_n=0 sampled on a rising edge -> state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry and counter are cleared.
- Reset mid-operation aborts the addition. No done pulse is produced, and the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - load a and b into shift registers;
  - clear the carry register and the bit counter;
  - clear the partial-sum shift register;
  - go to RUN.
- IDLE with start=0: remain in IDLE.
- RUN, each edge:
  - s_bit = A[0] ^ B[0] ^ c, computed as half_adder(A0,B0) followed by half_adder(s1,c).
  - c_next = carry1 | carry2.
  - A and B shift right by one.
  - s_bit shifts into the MSB of the partial-sum register.
  - counter increments.
- RUN -> DONE: on the edge that processes bit WIDTH-1, i.e. the WIDTH-th RUN edge.
  - On that same edge, sum <= completed partial sum and cout <= c_next.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency: accept edge at edge 0 -> done high in the cycle after edge WIDTH. The next accept is possible at edge WIDTH+2, so the back-to-back period is WIDTH+2 cycles.
- start while busy=1 (RUN or DONE): ignored, with no queuing. start held high continuously gives back-to-back operations, one every WIDTH+2 cycles.
- a and b may change freely after the accept edge without affecting the result in progress.
- sum and cout hold their last result through IDLE and the next RUN. They update only on the RUN->DONE edge.
- done, busy, sum and cout are all driven from registers. There is no combinational path from the inputs to any output.
- Counter width: clog2(WIDTH)+1 bits. WIDTH=1 is legal: one RUN cycle, then DONE.
- Arithmetic: unsigned. Overflow appears only in cout; sum wraps modulo 2^WIDTH.

Test Plan:
1. WIDTH=8, reset 2 cycles, a=3, b=5, start pulse -> busy=1 from the next cycle; done pulses exactly 9 cycles after the accept edge; sum=8, cout=0; busy=0 the cycle after done.
2. a=255, b=1 -> sum=0, cout=1. a=255, b=255 -> sum=254, cout=1. a=0, b=0 -> sum=0, cout=0.
3. start held high with operand pairs (10,20) then (100,200) -> accepts spaced 10 cycles apart; results 30/0 then 44/1; exactly one done pulse per operation.
4. Mid-operation: after accepting a=7, b=9, change a/b every cycle and pulse start at RUN cycle 3 -> result is still sum=16, cout=0; exactly one done pulse.
5. rst_n=0 at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, and no done pulse ever follows. A new op a=200, b=100 then gives sum=44, cout=1.
6. WIDTH=1 build: a=1, b=1 -> done 2 cycles after accept, sum=0, cout=1. Also a random 1000-op sweep at WIDTH=8 against a reference model.
